// File: rtl/otn_pkg.sv
// rtl/otn_pkg.sv - shared frame constants, demapper state type and CRC-8 step function
package otn_pkg;

  localparam logic [7:0] FAS0_BYTE = 8'hF6;
  localparam logic [7:0] FAS1_BYTE = 8'h28;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    HUNT,
    GOT_F0,
    PYLD,
    CRC,
    DRAIN
  } state_t;

  // CRC-8, poly 0x07, MSB-first, no reflection, no final XOR
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_acc.sv
// rtl/crc8_acc.sv - byte-wide CRC-8 accumulator with clear and enable
module crc8_acc
  import otn_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] crc_q, crc_d;

  // clear wins over enable so a new frame always starts from zero
  always_comb begin
    crc_d = crc_q;
    if (i_clear) begin
      crc_d = 8'h00;
    end else if (i_enable) begin
      crc_d = crc8_byte(crc_q, i_data);
    end
  end

  // accumulator register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/demapper.sv
// rtl/demapper.sv - frame hunter, payload buffer and CRC checker; DEMAPPER_CRC_EN enables CRC checking
module demapper
  import otn_pkg::*;
#(
  parameter int unsigned PYLD_LEN = 8,
  parameter logic [7:0]  FAS0     = FAS0_BYTE,
  parameter logic [7:0]  FAS1     = FAS1_BYTE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  output logic       o_frame_data_ready,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_pyld_data_ready,
  output logic       o_ack_valid,
  output logic       o_ack_good,
  output logic [7:0] o_crc_val,
  output logic [7:0] o_crc_err_cnt
);

`ifdef DEMAPPER_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  localparam int unsigned IW = $clog2(PYLD_LEN);
  localparam logic [IW-1:0] LAST = IW'(PYLD_LEN - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, idx_inc;
  logic [7:0]      buf_q [PYLD_LEN];
  logic [7:0]      buf_d [PYLD_LEN];
  logic [7:0]      crc_val_q, crc_val_d;
  logic [7:0]      err_q, err_d;
  logic            ack_valid_q, ack_valid_d;
  logic            ack_good_q, ack_good_d;
  logic            pyld_valid_q, pyld_valid_d;
  logic [7:0]      pyld_data_q, pyld_data_d;
  logic            accept, crc_clr, crc_step, frame_good;
  logic [7:0]      crc_acc;

  assign o_frame_data_ready = (state_q != DRAIN);
  assign accept             = i_frame_data_valid && o_frame_data_ready;
  assign idx_inc            = idx_q + IW'(1);

  crc8_acc u_crc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (crc_clr),
    .i_enable (crc_step),
    .i_data   (i_frame_data),
    .o_crc    (crc_acc)
  );

  // frame FSM: alignment hunt, payload capture, CRC compare and payload drain
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    crc_val_d    = crc_val_q;
    err_d        = err_q;
    ack_valid_d  = 1'b0;
    ack_good_d   = 1'b0;
    pyld_valid_d = pyld_valid_q;
    pyld_data_d  = pyld_data_q;
    crc_clr      = 1'b0;
    crc_step     = 1'b0;
    frame_good   = !CRC_EN || (i_frame_data == crc_acc);
    case (state_q)
      HUNT: begin
        if (accept && i_frame_data == FAS0) state_d = GOT_F0;
      end
      GOT_F0: begin
        if (accept) begin
          if (i_frame_data == FAS1) begin
            state_d = PYLD;
            idx_d   = '0;
            crc_clr = 1'b1;
          end else if (i_frame_data != FAS0) begin
            state_d = HUNT;
          end
        end
      end
      PYLD: begin
        if (accept) begin
          buf_d[idx_q] = i_frame_data;
          crc_step     = 1'b1;
          if (idx_q == LAST) state_d = CRC;
          else               idx_d   = idx_inc;
        end
      end
      CRC: begin
        if (accept) begin
          crc_val_d   = CRC_EN ? crc_acc : 8'h00;
          ack_valid_d = 1'b1;
          ack_good_d  = frame_good;
          if (frame_good) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else begin
            state_d = HUNT;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        // first cycle loads the output register; afterwards advance only on a taken byte
        if (!pyld_valid_q) begin
          pyld_valid_d = 1'b1;
          pyld_data_d  = buf_q[idx_q];
        end else if (i_pyld_data_ready) begin
          if (idx_q == LAST) begin
            pyld_valid_d = 1'b0;
            state_d      = HUNT;
          end else begin
            idx_d       = idx_inc;
            pyld_data_d = buf_q[idx_inc];
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // state and output registers; reset discards any partial frame or drain
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      buf_q        <= '{default: 8'h00};
      crc_val_q    <= 8'h00;
      err_q        <= 8'h00;
      ack_valid_q  <= 1'b0;
      ack_good_q   <= 1'b0;
      pyld_valid_q <= 1'b0;
      pyld_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      crc_val_q    <= crc_val_d;
      err_q        <= err_d;
      ack_valid_q  <= ack_valid_d;
      ack_good_q   <= ack_good_d;
      pyld_valid_q <= pyld_valid_d;
      pyld_data_q  <= pyld_data_d;
    end
  end

  assign o_pyld_data       = pyld_data_q;
  assign o_pyld_data_valid = pyld_valid_q;
  assign o_ack_valid       = ack_valid_q;
  assign o_ack_good        = ack_good_q;
  assign o_crc_val         = crc_val_q;
  assign o_crc_err_cnt     = err_q;

endmodule

// File: tb/tb_demapper.sv
// tb/tb_demapper.sv - scoreboard bench for demapper with random frames and a bit-serial CRC model
module tb_demapper;

  localparam int N = 8;

`ifdef DEMAPPER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef logic [7:0] pl_t [N];
  typedef struct {
    bit         good;
    logic [7:0] crc;
    logic [7:0] err;
  } ack_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_frame_data = 8'h00;
  logic       i_frame_data_valid = 1'b0;
  logic       o_frame_data_ready;
  logic [7:0] o_pyld_data;
  logic       o_pyld_data_valid;
  logic       i_pyld_data_ready = 1'b1;
  logic       o_ack_valid;
  logic       o_ack_good;
  logic [7:0] o_crc_val;
  logic [7:0] o_crc_err_cnt;

  int         total = 0;
  int         bad = 0;
  ack_t       ack_q[$];
  logic [7:0] pyld_q[$];
  int         exp_err = 0;
  int         taken = 0;
  bit         bp = 1'b0;

  demapper #(.PYLD_LEN(N)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .o_frame_data_ready (o_frame_data_ready),
    .o_pyld_data        (o_pyld_data),
    .o_pyld_data_valid  (o_pyld_data_valid),
    .i_pyld_data_ready  (i_pyld_data_ready),
    .o_ack_valid        (o_ack_valid),
    .o_ack_good         (o_ack_good),
    .o_crc_val          (o_crc_val),
    .o_crc_err_cnt      (o_crc_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // message treated as a bit stream through a shift-register divider
  function automatic logic [7:0] crc_ref(input pl_t p);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < N; i++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ p[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] rand_not_fas0();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == 8'hF6) b = 8'($urandom);
    return b;
  endfunction

  function automatic pl_t rand_payload();
    pl_t p;
    for (int i = 0; i < N; i++) p[i] = 8'($urandom);
    return p;
  endfunction

  // called at a negedge, returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_frame_data       = b;
    i_frame_data_valid = 1'b1;
    while (!o_frame_data_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) fail_now("send_timeout");
    @(negedge i_clk);
    i_frame_data_valid = 1'b0;
  endtask

  task automatic send_frame(input pl_t p, input logic [7:0] xmask);
    logic [7:0] c;
    ack_t a;
    c      = crc_ref(p);
    a.good = !CRC_ON || (xmask == 8'h00);
    if (!a.good && exp_err < 255) exp_err++;
    a.crc  = CRC_ON ? c : 8'h00;
    a.err  = 8'(exp_err);
    ack_q.push_back(a);
    if (a.good) for (int i = 0; i < N; i++) pyld_q.push_back(p[i]);
    send_byte(8'hF6);
    send_byte(8'h28);
    for (int i = 0; i < N; i++) send_byte(p[i]);
    send_byte(c ^ xmask);
    check("ack_latency", o_ack_valid, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pyld_q.size() != 0 || ack_q.size() != 0) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
    @(negedge i_clk);
    check("ready_after_drain", o_frame_data_ready, 1);
  endtask

  // client ready, changed away from the sampling edge
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_pyld_data_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ack monitor
  initial begin
    ack_t a;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_ack_valid) begin
        if (ack_q.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          a = ack_q.pop_front();
          check("ack_good", o_ack_good, a.good);
          check("crc_val", o_crc_val, a.crc);
          check("crc_err_cnt", o_crc_err_cnt, a.err);
          if (a.good) begin
            @(negedge i_clk);
            check("pyld_latency", o_pyld_data_valid, 1);
          end
        end
      end
    end
  end

  // payload monitor
  initial begin
    logic [7:0] pd;
    bit pv, pr;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", o_pyld_data_valid, 1);
          check("hold_data", o_pyld_data, pd);
        end
        if (o_pyld_data_valid) check("stall_in_drain", o_frame_data_ready, 0);
        if (o_pyld_data_valid && i_pyld_data_ready) begin
          if (pyld_q.size() == 0) fail_now("unexpected_payload");
          else check("pyld_data", o_pyld_data, pyld_q.pop_front());
          taken++;
        end
        pv = o_pyld_data_valid;
        pr = i_pyld_data_ready;
        pd = o_pyld_data;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    pl_t p;
    int base, n, g;
    logic [7:0] m;

    i_rst_n = 1'b0;
    repeat (5) @(negedge i_clk);
    check("rst_pyld_valid", o_pyld_data_valid, 0);
    check("rst_ack_valid", o_ack_valid, 0);
    check("rst_ack_good", o_ack_good, 0);
    check("rst_frame_ready", o_frame_data_ready, 1);
    check("rst_err_cnt", o_crc_err_cnt, 0);
    check("rst_crc_val", o_crc_val, 0);
    check("rst_pyld_data", o_pyld_data, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < N; i++) p[i] = 8'(i + 1);
    send_frame(p, 8'h00);
    wait_drain();

    send_frame(p, 8'h01);
    wait_drain();
    check("err_after_bad", o_crc_err_cnt, exp_err);

    send_byte(8'hAA);
    send_byte(8'hF6);
    send_frame(rand_payload(), 8'h00);
    wait_drain();

    send_byte(8'hF6);
    send_byte(8'h55);
    send_byte(8'h28);
    send_frame(rand_payload(), 8'h00);
    wait_drain();

    bp = 1'b1;
    for (int f = 0; f < 12; f++) begin
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) send_byte(rand_not_fas0());
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(rand_payload(), m);
    end
    wait_drain();
    bp = 1'b0;
    @(negedge i_clk);

    base = taken;
    send_frame(rand_payload(), 8'h00);
    n = 0;
    while (taken < base + 3 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) fail_now("mid_drain_timeout");
    i_rst_n = 1'b0;
    pyld_q.delete();
    ack_q.delete();
    exp_err = 0;
    repeat (5) @(negedge i_clk);
    check("mid_rst_pyld_valid", o_pyld_data_valid, 0);
    check("mid_rst_ack_valid", o_ack_valid, 0);
    check("mid_rst_frame_ready", o_frame_data_ready, 1);
    check("mid_rst_err_cnt", o_crc_err_cnt, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    send_frame(rand_payload(), 8'h00);
    wait_drain();

    for (int f = 0; f < 260; f++) send_frame(rand_payload(), 8'h01);
    wait_drain();
    check("err_saturated", o_crc_err_cnt, exp_err);

    check("ack_q_empty", ack_q.size(), 0);
    check("pyld_q_empty", pyld_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
